tx_fifo_arbiter: RTL
====================

TX_FIFO_ARBITER -- requirements
Module: tx_fifo_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
  WIDTH  8  data width in bits
  DEPTH  16  entries in the shared FIFO
  ADDR_BITS  $clog2(DEPTH)  FIFO address width
REQ-002 Ports SHALL be, one per line:
  clk  in  1  single clock, rising edge
  rst  in  1  asynchronous, active-high reset
  req_a  in  1  requester A has a packet to send
  len_a  in  ADDR_BITS+1  A packet length in beats, sampled at grant
  a_valid  in  1  A beat valid
  a_data  in  WIDTH  A beat data
  a_ready  out  1  A beat accepted
  req_b, len_b, b_valid, b_data, b_ready  --  identical to the A ports, for requester B
  fifo_free  in  ADDR_BITS+1  free entries reported by the FIFO
  fifo_wr_en  out  1  FIFO write strobe
  fifo_wr_data  out  WIDTH  FIFO write data
  gnt  out  2  one-hot grant; bit0 = A, bit1 = B
  busy  out  1  packet in progress
  err_len  out  1  illegal length flag
REQ-003 There SHALL be one clock domain, clk; rst SHALL be asynchronous and active-high.

Function
REQ-004 The FSM SHALL have exactly two states, IDLE and XFER.
REQ-005 In IDLE, requester x SHALL be eligible when req_x=1, 1<=len_x<=DEPTH, and fifo_free>=len_x (unsigned compare).
REQ-006 In IDLE with at least one eligible requester, the FSM SHALL go to XFER on the next edge:
  - gnt set to the winner
  - remaining counter loaded with the winner's len
  - busy=1
REQ-007 Arbitration SHALL be round-robin:
  - only one eligible: it wins
  - both eligible: the priority pointer decides
  - pointer = A after reset; flips to the non-winner at packet end
REQ-008 Grant latency SHALL be one cycle: req sampled in cycle N, gnt visible in cycle N+1.
REQ-009 In XFER, the following SHALL be combinational from gnt:
  - x_ready = gnt[x]
  - fifo_wr_en = x_valid & gnt[x]
  - fifo_wr_data = x_data
  - non-granted ready = 0
REQ-010 Each accepted beat (valid & ready) SHALL decrement remaining by 1; valid=0 cycles SHALL stall without penalty.
REQ-011 A beat accepted with remaining=1 SHALL complete the packet; on the next edge:
  - state returns to IDLE
  - gnt=00, busy=0
  - priority pointer updated
REQ-012 Between packets there SHALL be at least one IDLE cycle, so back-to-back grants are 2 cycles apart minimum.
REQ-013 In IDLE, fifo_wr_en, a_ready and b_ready SHALL all be 0.
REQ-014 Space is reserved at grant time, and FIFO reads only increase fifo_free; the block therefore SHALL never pulse fifo_wr_en while the FIFO is full.
REQ-015 Deassertion of req_x during XFER SHALL be ignored; the packet SHALL run to its latched length.
REQ-016 Changes to len_x or fifo_free during XFER SHALL have no effect.
REQ-017 err_len SHALL be registered and SHALL be 1 for each IDLE cycle following one where a requester has req=1 with len=0 or len>DEPTH.
REQ-018 An illegal request SHALL never be granted and SHALL NOT block the other requester.
REQ-019 A request with len>fifo_free SHALL wait without error; the other requester MAY be granted meanwhile.

Reset
REQ-020 While rst=1, the block SHALL immediately (asynchronously) force:
  - state=IDLE
  - gnt=00, busy=0, err_len=0
  - remaining=0
  - priority pointer = A
  - fifo_wr_en=0, a_ready=0, b_ready=0
REQ-021 Reset mid-packet SHALL abandon the packet; no beat SHALL be written after rst asserts.
REQ-022 The first grant after reset release SHALL occur no earlier than the second rising edge after deassertion.

Verification
REQ-023 The bench SHALL cover the following scenarios:
  - Reset: rst pulse mid-XFER -> gnt=00, busy=0, fifo_wr_en=0 in the same cycle; next grant goes to A when both request.
  - Single packet: req_a=1, len_a=3, fifo_free=16, a_valid constant -> gnt=01 at N+1; three fifo_wr_en pulses with a_data; gnt=00 after the third beat.
  - Round-robin: req_a=req_b=1, both len=2, free=16 -> A packet, one IDLE cycle, B packet; repeat -> A again.
  - Space gating: fifo_free=2, len_a=4, len_b=2 -> B granted, A waits; free rises to 4 -> A granted after B completes.
  - Illegal length: req_a=1, len_a=0 -> err_len=1, no grant; req_b with len_b=1 is still granted.
  - Stall: a_valid toggling 1,0,0,1 with len_a=2 -> exactly two writes; remaining holds during stalls.

Source files
------------

// File: rtl/tx_fifo_arbiter.sv
// Round-robin arbiter moving whole packets from two requesters into a shared FIFO.
// Grant one cycle after an eligible request; beats pass through combinationally and stall on valid=0.
module tx_fifo_arbiter #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_a,
  input  logic [ADDR_BITS:0]   len_a,
  input  logic                 a_valid,
  input  logic [WIDTH-1:0]     a_data,
  output logic                 a_ready,
  input  logic                 req_b,
  input  logic [ADDR_BITS:0]   len_b,
  input  logic                 b_valid,
  input  logic [WIDTH-1:0]     b_data,
  output logic                 b_ready,
  input  logic [ADDR_BITS:0]   fifo_free,
  output logic                 fifo_wr_en,
  output logic [WIDTH-1:0]     fifo_wr_data,
  output logic [1:0]           gnt,
  output logic                 busy,
  output logic                 err_len
);

  localparam logic [ADDR_BITS:0] MAX_LEN = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS:0] ONE     = (ADDR_BITS+1)'(1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t             state_q, state_d;
  logic [1:0]         gnt_q, gnt_d;
  logic [ADDR_BITS:0] rem_q, rem_d;
  logic               ptr_q, ptr_d;
  logic               err_q, err_d;
  logic               live_q;

  logic bad_a, bad_b, elig_a, elig_b, win_b, beat;

  assign bad_a  = req_a && ((len_a == '0) || (len_a > MAX_LEN));
  assign bad_b  = req_b && ((len_b == '0) || (len_b > MAX_LEN));
  assign elig_a = req_a && !bad_a && (fifo_free >= len_a);
  assign elig_b = req_b && !bad_b && (fifo_free >= len_b);
  // ptr_q=1 favours B when both are eligible
  assign win_b  = elig_b && (!elig_a || ptr_q);
  assign beat   = (gnt_q[0] & a_valid) | (gnt_q[1] & b_valid);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rem_d   = rem_q;
    ptr_d   = ptr_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        err_d = bad_a | bad_b;
        // live_q holds off grants until one edge after reset release
        if (live_q && (elig_a || elig_b)) begin
          state_d = XFER;
          gnt_d   = win_b ? 2'b10 : 2'b01;
          rem_d   = win_b ? len_b : len_a;
        end
      end
      XFER: begin
        if (beat) begin
          if (rem_q == ONE) begin
            state_d = IDLE;
            gnt_d   = 2'b00;
            rem_d   = '0;
            ptr_d   = gnt_q[0];
          end else begin
            rem_d = rem_q - ONE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      rem_q   <= '0;
      ptr_q   <= 1'b0;
      err_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rem_q   <= rem_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      live_q  <= 1'b1;
    end
  end

  assign a_ready      = gnt_q[0];
  assign b_ready      = gnt_q[1];
  assign fifo_wr_en   = beat;
  assign fifo_wr_data = gnt_q[1] ? b_data : a_data;
  assign gnt          = gnt_q;
  assign busy         = (state_q == XFER);
  assign err_len      = err_q;

endmodule
